mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/mem_port_slot.sv | 51 +++++
 rtl/mem_ctrl.sv | 125 ++++++++++++
 tb/tb_mem_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_ctrl_pkg                                                       |
// | Shared encodings and request record for the cache memory control.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mem_ctrl_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] RLAST = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [1:0] RW_READ  = 2'b01;
  localparam logic [1:0] RW_WRITE = 2'b10;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } mem_req_t;

  // Both flag bits set falls back to a read.
  function automatic logic is_write(input logic [1:0] flag);
    return flag == RW_WRITE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_slot                                                      |
// | One-deep request latch per cache port with registered done/data.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_port_slot
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  rw_flag,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  write_mask,
  input  logic        release_slot,
  input  logic [31:0] rdata_word,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_data,
  output mem_req_t    req
);

  logic new_req;
  assign new_req = (rw_flag & (RW_READ | RW_WRITE)) != 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      read_data <= '0;
      req       <= '0;
    end else begin
      done <= 1'b0;
      // Releasing frees the slot so a request in the done cycle is taken.
      if (release_slot) begin
        busy <= 1'b0;
        done <= 1'b1;
        if (!req.write) read_data <= rdata_word;
      end else if (!busy && new_req) begin
        busy       <= 1'b1;
        req.write  <= is_write(rw_flag);
        req.addr   <= addr;
        req.data   <= write_data;
        req.mask   <= write_mask;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_ctrl                                                           |
// | Arbitrates icache/dcache word requests onto a byte-wide sync RAM.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [1:0]            p0_rw_flag,
  input  logic [31:0]           p0_addr,
  input  logic [31:0]           p0_write_data,
  input  logic [3:0]            p0_write_mask,
  output logic [31:0]           p0_read_data,
  output logic                  p0_busy,
  output logic                  p0_done,
  input  logic [1:0]            p1_rw_flag,
  input  logic [31:0]           p1_addr,
  input  logic [31:0]           p1_write_data,
  input  logic [3:0]            p1_write_mask,
  output logic [31:0]           p1_read_data,
  output logic                  p1_busy,
  output logic                  p1_done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [7:0]            ram_wdata,
  output logic                  ram_we,
  input  logic [7:0]            ram_rdata
);

  logic [1:0]  state;
  logic [1:0]  idx;
  logic        gnt;
  logic        last_grant;
  logic [23:0] rbuf;
  mem_req_t    req0, req1, cur;
  logic        arb_gnt, arb_write;
  logic        rel;
  logic [31:0] rdata_word;
  logic        unused_addr_bits;

  assign rel        = (state == RLAST) || (state == WRITE && idx == 2'd3);
  assign rdata_word = {ram_rdata, rbuf};

  mem_port_slot u_slot0 (
    .clk(CLK), .rst_n(RST_N),
    .rw_flag(p0_rw_flag), .addr(p0_addr), .write_data(p0_write_data),
    .write_mask(p0_write_mask), .release_slot(rel && gnt == PORT0),
    .rdata_word(rdata_word), .busy(p0_busy), .done(p0_done),
    .read_data(p0_read_data), .req(req0)
  );

  mem_port_slot u_slot1 (
    .clk(CLK), .rst_n(RST_N),
    .rw_flag(p1_rw_flag), .addr(p1_addr), .write_data(p1_write_data),
    .write_mask(p1_write_mask), .release_slot(rel && gnt == PORT1),
    .rdata_word(rdata_word), .busy(p1_busy), .done(p1_done),
    .read_data(p1_read_data), .req(req1)
  );

  // Round-robin only breaks ties; a lone request is granted directly.
  always_comb begin
    if (p0_busy && p1_busy) arb_gnt = ~last_grant;
    else if (p1_busy)       arb_gnt = PORT1;
    else                    arb_gnt = PORT0;
    arb_write = (arb_gnt == PORT1) ? req1.write : req0.write;
    cur       = (gnt == PORT1) ? req1 : req0;
  end

  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    if (state == READ || state == WRITE) ram_addr = {cur.addr[ADDR_WIDTH-1:2], idx};
    if (state == WRITE) begin
      ram_wdata = cur.data[{idx, 3'b000} +: 8];
      ram_we    = cur.mask[idx];
    end
  end

  assign unused_addr_bits = ^{cur.addr[31:ADDR_WIDTH], cur.addr[1:0]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= IDLE;
      idx        <= 2'd0;
      gnt        <= PORT0;
      last_grant <= PORT1;
      rbuf       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (p0_busy || p1_busy) begin
            gnt <= arb_gnt;
            if (p0_busy && p1_busy) last_grant <= arb_gnt;
            idx   <= 2'd0;
            state <= arb_write ? WRITE : READ;
          end
        end
        READ: begin
          // RAM read data lags the address by one cycle.
          case (idx)
            2'd1:    rbuf[7:0]   <= ram_rdata;
            2'd2:    rbuf[15:8]  <= ram_rdata;
            2'd3:    rbuf[23:16] <= ram_rdata;
            default: ;
          endcase
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= RLAST;
        end
        RLAST: state <= IDLE;
        WRITE: begin
          idx <= idx + 2'd1;
          if (idx == 2'd3) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_ctrl                                                        |
// | Directed scoreboard bench for mem_ctrl with a byte-wide RAM model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  p0_rw_flag = '0, p1_rw_flag = '0;
  logic [31:0] p0_addr = '0, p1_addr = '0;
  logic [31:0] p0_write_data = '0, p1_write_data = '0;
  logic [3:0]  p0_write_mask = '0, p1_write_mask = '0;
  logic [31:0] p0_read_data, p1_read_data;
  logic        p0_busy, p1_busy, p0_done, p1_done;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = '0;

  typedef struct {
    int          cyc;
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   we_count = 0;
  int   wc;
  logic [7:0] mem [0:131071];

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_WIDTH(17)) dut (
    .CLK(clk), .RST_N(rst_n),
    .p0_rw_flag(p0_rw_flag), .p0_addr(p0_addr), .p0_write_data(p0_write_data),
    .p0_write_mask(p0_write_mask), .p0_read_data(p0_read_data),
    .p0_busy(p0_busy), .p0_done(p0_done),
    .p1_rw_flag(p1_rw_flag), .p1_addr(p1_addr), .p1_write_data(p1_write_data),
    .p1_write_mask(p1_write_mask), .p1_read_data(p1_read_data),
    .p1_busy(p1_busy), .p1_done(p1_done),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    if (ram_we) we_count <= we_count + 1;
    cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_done(input int p, input logic [31:0] rd);
    exp_t e;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_done p%0d: got done=1 required done=0 (cycle %0d)", p, cyc);
      return;
    end
    if (p == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    check($sformatf("p%0d_done_cycle", p), cyc, e.cyc);
    if (e.is_rd) check($sformatf("p%0d_read_data", p), rd, e.data);
  endtask

  always @(negedge clk) begin
    if (p0_done) check_done(0, p0_read_data);
    if (p1_done) check_done(1, p1_read_data);
  end

  // Called at a falling edge; lat = 0 means the request is expected to be dropped.
  task automatic issue(input int p, input logic [1:0] flag, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] m, input int lat,
                       input logic [31:0] exp_rd);
    exp_t e;
    e.cyc   = cyc + lat;
    e.is_rd = (flag != RW_WRITE);
    e.data  = exp_rd;
    if (p == 0) begin
      p0_rw_flag = flag; p0_addr = a; p0_write_data = d; p0_write_mask = m;
      if (lat > 0) q0.push_back(e);
    end else begin
      p1_rw_flag = flag; p1_addr = a; p1_write_data = d; p1_write_mask = m;
      if (lat > 0) q1.push_back(e);
    end
  endtask

  task automatic step();
    @(negedge clk);
    p0_rw_flag = 2'b00;
    p1_rw_flag = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || p0_busy || p1_busy) && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (n >= 60) begin
      failures++;
      $display("FAIL idle_timeout: got pending p0=%0d p1=%0d required 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    repeat (3) step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p0_busy"}, {31'b0, p0_busy}, 32'd0);
    check({tag, "_p1_busy"}, {31'b0, p1_busy}, 32'd0);
    check({tag, "_p0_done"}, {31'b0, p0_done}, 32'd0);
    check({tag, "_p1_done"}, {31'b0, p1_done}, 32'd0);
    check({tag, "_p0_read_data"}, p0_read_data, 32'd0);
    check({tag, "_p1_read_data"}, p1_read_data, 32'd0);
    check({tag, "_ram_addr"}, {15'b0, ram_addr}, 32'd0);
    check({tag, "_ram_we"}, {31'b0, ram_we}, 32'd0);
    check({tag, "_ram_wdata"}, {24'b0, ram_wdata}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;
    mem[32] = 8'h01; mem[33] = 8'h02; mem[34] = 8'h03; mem[35] = 8'h04;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Single read, no RAM writes.
    wc = we_count;
    issue(0, RW_READ, 32'h0000_0010, 32'h0, 4'h0, 7, 32'h4433_2211);
    step();
    wait_idle();
    check("read_no_we", we_count, wc);

    // Masked write; upper address bits and bits [1:0] are ignored.
    issue(1, RW_WRITE, 32'hFFFE_0023, 32'hAABB_CCDD, 4'b0101, 6, 32'h0);
    step();
    wait_idle();
    check("mem20", {24'b0, mem[32'h20]}, 32'hDD);
    check("mem21", {24'b0, mem[32'h21]}, 32'h02);
    check("mem22", {24'b0, mem[32'h22]}, 32'hBB);
    check("mem23", {24'b0, mem[32'h23]}, 32'h04);

    // Contention: p0 first after reset, then p1 first.
    issue(0, RW_READ, 32'h10, 32'h0, 4'h0, 7,  32'h4433_2211);
    issue(1, RW_READ, 32'h20, 32'h0, 4'h0, 13, 32'h04BB_02DD);
    step();
    wait_idle();
    issue(0, RW_READ, 32'h10, 32'h0, 4'h0, 13, 32'h4433_2211);
    issue(1, RW_READ, 32'h20, 32'h0, 4'h0, 7,  32'h04BB_02DD);
    step();
    wait_idle();

    // Back-to-back: second request issued in the done cycle.
    issue(0, RW_READ, 32'h10, 32'h0, 4'h0, 7, 32'h4433_2211);
    for (int i = 0; i < 6; i++) begin
      step();
      check("b2b_busy_first", {31'b0, p0_busy}, 32'd1);
    end
    step();
    issue(0, RW_READ, 32'h20, 32'h0, 4'h0, 7, 32'h04BB_02DD);
    for (int i = 0; i < 6; i++) begin
      step();
      check("b2b_busy_second", {31'b0, p0_busy}, 32'd1);
    end
    wait_idle();

    // Reset while READ is at idx 2.
    issue(0, RW_READ, 32'h10, 32'h0, 4'h0, 0, 32'h0);
    repeat (4) step();
    check("mid_ram_addr", {15'b0, ram_addr}, 32'h12);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    step();
    step();
    rst_n = 1'b1;
    step();
    issue(0, RW_READ, 32'h10, 32'h0, 4'h0, 7, 32'h4433_2211);
    step();
    wait_idle();

    // Empty mask, plus a dropped request while busy.
    wc = we_count;
    issue(1, RW_WRITE, 32'h20, 32'h5555_5555, 4'h0, 6, 32'h0);
    step();
    step();
    check("drop_busy", {31'b0, p1_busy}, 32'd1);
    issue(1, RW_WRITE, 32'h30, 32'hFFFF_FFFF, 4'hF, 0, 32'h0);
    step();
    wait_idle();
    check("empty_mask_no_we", we_count, wc);
    check("drop_mem30", {24'b0, mem[32'h30]}, 32'h00);
    check("keep_mem20", {24'b0, mem[32'h20]}, 32'hDD);

    // A write completion leaves the port's read data intact.
    issue(0, RW_WRITE, 32'h40, 32'h1234_5678, 4'h0, 6, 32'h0);
    step();
    wait_idle();
    check("write_keeps_read_data", p0_read_data, 32'h4433_2211);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
